// File: rtl/exec_unit.sv
// Execute stage sitting behind reg_file: latches two operands and an opcode,
// runs single-cycle ALU ops or an iterative shift-add multiply, and emits a
// one-cycle write-back strobe with result, flags and destination select.
//
// Handshake: START is a request that is honoured only while the block is
// IDLE (BUSY low); requests seen while BUSY are dropped, never queued. Each
// accepted request yields exactly one WR_EN/DONE cycle. An accepted op that
// is cut short by reset produces no strobe at all.
module exec_unit #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic [2:0]       OPCODE,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    input  logic [SEL_W-1:0] DEST,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             WR_EN,
    output logic [SEL_W-1:0] WR_SEL,
    output logic [3:0]       FLAGS,
    output logic [1:0]       DBG_STATE
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    state_t               r_state;
    state_t               w_next;
    op_t                  r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_prod;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_result;
    logic [3:0]           r_flags;
    logic [SEL_W-1:0]     r_wr_sel;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_a_ext;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_c;
    logic                 w_alu_v;
    logic [3:0]           w_flags;

    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
    assign w_a_ext = {{WIDTH{1'b0}}, r_a};

    // State register; reset aborts whatever op is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and status outputs; WB is the only strobe state.
    always_comb begin
        w_next    = r_state;
        BUSY      = (r_state != S_IDLE);
        WR_EN     = (r_state == S_WB);
        DONE      = (r_state == S_WB);
        DBG_STATE = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next = (OPCODE == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_MUL: begin
                // Last partial product goes in this cycle; EXEC then
                // derives result and flags from the finished product.
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ALU: result plus carry/overflow for the latched op.
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_alu_c   = w_diff[WIDTH];
                w_alu_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_AND: w_alu_res = r_a & r_b;
            OP_OR:  w_alu_res = r_a | r_b;
            OP_XOR: w_alu_res = r_a ^ r_b;
            OP_SHL: begin
                w_alu_res = {r_a[WIDTH-2:0], 1'b0};
                w_alu_c   = r_a[WIDTH-1];
            end
            OP_SHR: begin
                w_alu_res = {1'b0, r_a[WIDTH-1:1]};
                w_alu_c   = r_a[0];
            end
            OP_MUL: begin
                w_alu_res = r_prod[WIDTH-1:0];
                w_alu_c   = |r_prod[2*WIDTH-1:WIDTH];
                w_alu_v   = |r_prod[2*WIDTH-1:WIDTH];
            end
            default: begin
                w_alu_res = '0;
            end
        endcase
        w_flags = {(w_alu_res == '0), w_alu_res[WIDTH-1], w_alu_c, w_alu_v};
    end

    // Datapath: operand latch on accept, shift-add steps, result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_wr_sel <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_op     <= op_t'(OPCODE);
                        r_a      <= IN_A;
                        r_b      <= IN_B;
                        r_wr_sel <= DEST;
                        r_prod   <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_MUL: begin
                    if (r_b[r_cnt]) begin
                        r_prod <= r_prod + (w_a_ext << r_cnt);
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                S_EXEC: begin
                    r_result <= w_alu_res;
                    r_flags  <= w_flags;
                end
                default: begin
                end
            endcase
        end
    end

    assign RESULT = r_result;
    assign FLAGS  = r_flags;
    assign WR_SEL = r_wr_sel;

endmodule
